stw_sequencer: RTL

- Array-level self-test-while-working (STW) controller that drives the STW test interface of every PE in a systolic row/array and collects their pass/fail results.
- Sits directly upstream of the PE STW ports: broadcasts test operands and the expected result, pulses the start, waits for all PEs to complete, and accumulates a per-PE fault map.
- The fault map is consumed by the weight-proxy/repair controller. `sa_stall` is asserted to freeze the array datapath during a test run.

---
 rtl/stw_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/stw_sequencer.sv
// Array-level self-test-while-working controller: broadcasts four fixed test
// vectors to every PE, waits for all completions and accumulates a fault map.
module stw_sequencer #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_PE      = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_test,
  output logic                 stw_test_load_en,
  output logic [WORD_SIZE-1:0] stw_mult_op1,
  output logic [WORD_SIZE-1:0] stw_mult_op2,
  output logic [WORD_SIZE-1:0] stw_add_op,
  output logic [WORD_SIZE-1:0] stw_expected,
  output logic                 stw_start,
  input  logic [NUM_PE-1:0]    stw_complete,
  input  logic [NUM_PE-1:0]    stw_result,
  output logic                 sa_stall,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PE-1:0]    fault_map,
  output logic                 any_fault,
  output logic                 timeout_err,
  output logic [1:0]           vec_idx
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [WORD_SIZE-1:0] alt_ones();
    logic [WORD_SIZE-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < WORD_SIZE; i += 2) v[i] = 1'b1;
    return v;
  endfunction

  localparam logic [WORD_SIZE-1:0] ALT     = alt_ones();
  localparam logic [WORD_SIZE-1:0] ALT_X2  = {ALT[WORD_SIZE-2:0], 1'b0};
  localparam logic [WORD_SIZE-1:0] W_ONE   = WORD_SIZE'(1);
  localparam logic [WORD_SIZE-1:0] W_TWO   = WORD_SIZE'(2);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, CHECK, FINISH
  } state_t;

  state_t              state, state_nx;
  logic [1:0]          vec_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [NUM_PE-1:0]   fault_nx;
  logic                tmo_nx;
  logic [WORD_SIZE-1:0] op1_nx, op2_nx, add_nx, exp_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vec_idx      <= '0;
      cnt          <= '0;
      fault_map    <= '0;
      timeout_err  <= 1'b0;
      stw_mult_op1 <= '0;
      stw_mult_op2 <= '0;
      stw_add_op   <= '0;
      stw_expected <= '0;
    end else begin
      state       <= state_nx;
      vec_idx     <= vec_nx;
      cnt         <= cnt_nx;
      fault_map   <= fault_nx;
      timeout_err <= tmo_nx;
      // Buses are loaded on the edge entering LOAD so the PEs see them during the strobe
      if (state_nx == LOAD) begin
        stw_mult_op1 <= op1_nx;
        stw_mult_op2 <= op2_nx;
        stw_add_op   <= add_nx;
        stw_expected <= exp_nx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    vec_nx   = vec_idx;
    cnt_nx   = cnt;
    fault_nx = fault_map;
    tmo_nx   = timeout_err;
    unique case (state)
      IDLE: begin
        if (start_test) begin
          fault_nx = '0;
          tmo_nx   = 1'b0;
          vec_nx   = '0;
          state_nx = LOAD;
        end
      end
      LOAD:  state_nx = START;
      START: begin
        cnt_nx   = '0;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (stw_complete == '0) begin
          cnt_nx   = '0;
          state_nx = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_nx   = 1'b1;
          fault_nx = fault_map | stw_complete;
          state_nx = FINISH;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (stw_complete == '1) begin
          state_nx = CHECK;
        end else if (cnt == CNT_LAST) begin
          tmo_nx   = 1'b1;
          fault_nx = fault_map | ~stw_complete;
          state_nx = FINISH;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      CHECK: begin
        fault_nx = fault_map | ~stw_result;
        if (vec_idx == 2'd3) begin
          state_nx = FINISH;
        end else begin
          vec_nx   = vec_idx + 2'd1;
          state_nx = LOAD;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op1_nx = '0;
    op2_nx = '0;
    add_nx = '0;
    exp_nx = '0;
    unique case (vec_nx)
      2'd0: begin op1_nx = W_ONE; op2_nx = W_ONE; exp_nx = W_ONE; end
      2'd1: begin op1_nx = '1;    op2_nx = '1;    exp_nx = W_ONE; end
      2'd2: begin op1_nx = ALT;   op2_nx = W_TWO; exp_nx = ALT_X2; end
      default: begin add_nx = '1; exp_nx = '1; end
    endcase
  end

  assign stw_test_load_en = (state == LOAD);
  assign stw_start        = (state == START);
  assign done             = (state == FINISH);
  assign busy             = (state != IDLE);
  assign sa_stall         = (state != IDLE);
  assign any_fault        = |fault_map;

endmodule
